// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped refill I-cache.
//   state_t      : refill FSM states
//   offset_w / index_w / tag_w : field widths derived from the cache geometry
//   addr_offset / addr_index / addr_tag : split a byte address into its fields
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MREQ   = 2'd1,
        REFILL = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int words_per_line, input int num_lines);
        return addr_w - 2 - offset_w(words_per_line) - index_w(num_lines);
    endfunction

    // Fields are returned 64 bits wide; callers size-cast to the exact field width.
    function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int words_per_line);
        return (addr >> 2) & 64'(words_per_line - 1);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int words_per_line,
                                               input int num_lines);
        return (addr >> (2 + offset_w(words_per_line))) & 64'(num_lines - 1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int words_per_line,
                                             input int num_lines);
        return addr >> (2 + offset_w(words_per_line) + index_w(num_lines));
    endfunction

endpackage

// File: rtl/icache_dm_refill_if.sv
// Request/response bundle used both for the CPU fetch port and the memory refill port.
//   master : drives req_valid/req_addr, receives req_ready and the response
//   slave  : receives the request, drives req_ready and the response
//   resp_hit is only meaningful on the CPU side.
interface icache_dm_refill_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_hit;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data, resp_hit
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data, resp_hit
    );
endinterface

// File: rtl/icache_tag_valid_array.sv
// Tag store and valid bits for the direct-mapped cache.
//   clear_all    : clears every valid bit at the next edge (wins over a write)
//   lookup_*     : combinational hit = valid && tag match on lookup_index
//   write_*      : installs a tag and sets its valid bit
// Valid bits are reset; tags are not.
module icache_tag_valid_array #(
    parameter int NUM_LINES = 64,
    parameter int INDEX_W   = 6,
    parameter int TAG_W     = 22
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_all,
    input  logic [INDEX_W-1:0] lookup_index,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               lookup_hit,
    input  logic               write_en,
    input  logic [INDEX_W-1:0] write_index,
    input  logic [TAG_W-1:0]   write_tag
);

    logic [TAG_W-1:0]     tag_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid_r;

    // Valid bits: async reset, whole-array clear, set on line install.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (clear_all) begin
            valid_r <= {NUM_LINES{1'b0}};
        end else if (write_en) begin
            valid_r[write_index] <= 1'b1;
        end
    end

    // Tag storage, written when a refill completes.
    always_ff @(posedge clk) begin
        if (write_en) begin
            tag_mem[write_index] <= write_tag;
        end
    end

    assign lookup_hit = valid_r[lookup_index] && (tag_mem[lookup_index] == lookup_tag);

endmodule

// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with multi-word lines and burst refill.
//   clk, reset_n   : clock, asynchronous active-low reset
//   cpu (slave)    : fetch request (req_valid/req_ready/req_addr) and one-cycle
//                    response pulse (resp_valid/resp_data/resp_hit)
//   mem (master)   : line refill request (req_valid/req_ready/req_addr, line aligned)
//                    and refill beats (resp_valid/resp_data, word 0 first)
//   invalidate_all : clears all valid bits (deferred to IDLE while a refill runs)
//   hit_count, miss_count : wrapping performance counters
module icache_dm_refill
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    icache_dm_refill_if.slave   cpu,
    icache_dm_refill_if.master  mem,
    input  logic                invalidate_all,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam int OFFSET_W = offset_w(WORDS_PER_LINE);
    localparam int INDEX_W  = index_w(NUM_LINES);
    localparam int TAG_W    = tag_w(ADDR_W, WORDS_PER_LINE, NUM_LINES);
    // Offset/beat registers keep at least one bit so single-word lines still elaborate.
    localparam int OFF_SW   = (OFFSET_W > 0) ? OFFSET_W : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS_PER_LINE * 4 - 1);
    localparam logic [OFF_SW-1:0] LAST_BEAT = OFF_SW'(WORDS_PER_LINE - 1);

    state_t              state_r;
    logic [INDEX_W-1:0]  index_r;
    logic [TAG_W-1:0]    tag_r;
    logic [OFF_SW-1:0]   offset_r;
    logic [OFF_SW-1:0]   beat_r;
    logic                resp_valid_r;
    logic                resp_hit_r;
    logic [DATA_W-1:0]   resp_data_r;
    logic                mem_req_valid_r;
    logic [ADDR_W-1:0]   mem_req_addr_r;
    logic                inv_pending_r;
    logic [31:0]         hit_count_r;
    logic [31:0]         miss_count_r;

    logic [DATA_W-1:0]   data_mem [NUM_LINES][WORDS_PER_LINE];

    logic [INDEX_W-1:0]  req_index_s;
    logic [TAG_W-1:0]    req_tag_s;
    logic [OFF_SW-1:0]   req_offset_s;
    logic                clear_s;
    logic                ready_s;
    logic                accept_s;
    logic                lookup_hit_s;
    logic                beat_fire_s;
    logic                line_done_s;

    assign req_offset_s = OFF_SW'(addr_offset(64'(cpu.req_addr), WORDS_PER_LINE));
    assign req_index_s  = INDEX_W'(addr_index(64'(cpu.req_addr), WORDS_PER_LINE, NUM_LINES));
    assign req_tag_s    = TAG_W'(addr_tag(64'(cpu.req_addr), WORDS_PER_LINE, NUM_LINES));

    // A clear (direct or deferred) occupies the IDLE cycle, so no fetch is taken then.
    assign clear_s     = (state_r == IDLE) && (invalidate_all || inv_pending_r);
    assign ready_s     = (state_r == IDLE) && !clear_s;
    assign accept_s    = cpu.req_valid && ready_s;
    assign beat_fire_s = (state_r == REFILL) && mem.resp_valid;
    assign line_done_s = beat_fire_s && (beat_r == LAST_BEAT);

    icache_tag_valid_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_tag_valid (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_all    (clear_s),
        .lookup_index (req_index_s),
        .lookup_tag   (req_tag_s),
        .lookup_hit   (lookup_hit_s),
        .write_en     (line_done_s),
        .write_index  (index_r),
        .write_tag    (tag_r)
    );

    // Refill FSM with registered CPU response, memory request and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            index_r         <= {INDEX_W{1'b0}};
            tag_r           <= {TAG_W{1'b0}};
            offset_r        <= {OFF_SW{1'b0}};
            beat_r          <= {OFF_SW{1'b0}};
            resp_valid_r    <= 1'b0;
            resp_hit_r      <= 1'b0;
            resp_data_r     <= {DATA_W{1'b0}};
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= {ADDR_W{1'b0}};
            hit_count_r     <= 32'd0;
            miss_count_r    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        index_r  <= req_index_s;
                        tag_r    <= req_tag_s;
                        offset_r <= req_offset_s;
                        if (lookup_hit_s) begin
                            resp_valid_r <= 1'b1;
                            resp_hit_r   <= 1'b1;
                            resp_data_r  <= data_mem[req_index_s][req_offset_s];
                            hit_count_r  <= hit_count_r + 32'd1;
                        end else begin
                            resp_valid_r    <= 1'b0;
                            miss_count_r    <= miss_count_r + 32'd1;
                            mem_req_valid_r <= 1'b1;
                            mem_req_addr_r  <= cpu.req_addr & LINE_MASK;
                            state_r         <= MREQ;
                        end
                    end else begin
                        resp_valid_r <= 1'b0;
                    end
                end
                MREQ: begin
                    if (mem.req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        beat_r          <= {OFF_SW{1'b0}};
                        state_r         <= REFILL;
                    end
                end
                REFILL: begin
                    if (beat_fire_s) begin
                        // The requested word is taken straight off the bus as it passes.
                        if (beat_r == offset_r) begin
                            resp_data_r <= mem.resp_data;
                        end
                        if (beat_r == LAST_BEAT) begin
                            beat_r       <= {OFF_SW{1'b0}};
                            resp_valid_r <= 1'b1;
                            resp_hit_r   <= 1'b0;
                            state_r      <= RESP;
                        end else begin
                            beat_r <= beat_r + OFF_SW'(1);
                        end
                    end
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    resp_valid_r    <= 1'b0;
                    mem_req_valid_r <= 1'b0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

    // Invalidate seen during a refill is held until the FSM is back in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inv_pending_r <= 1'b0;
        end else if (state_r == IDLE) begin
            inv_pending_r <= 1'b0;
        end else if (invalidate_all) begin
            inv_pending_r <= 1'b1;
        end
    end

    // Line data storage, filled beat by beat during refill.
    always_ff @(posedge clk) begin
        if (beat_fire_s) begin
            data_mem[index_r][beat_r] <= mem.resp_data;
        end
    end

    assign cpu.req_ready  = ready_s;
    assign cpu.resp_valid = resp_valid_r;
    assign cpu.resp_hit   = resp_hit_r;
    assign cpu.resp_data  = resp_data_r;
    assign mem.req_valid  = mem_req_valid_r;
    assign mem.req_addr   = mem_req_addr_r;
    assign hit_count      = hit_count_r;
    assign miss_count     = miss_count_r;

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed self-checking bench for icache_dm_refill (default geometry: 64 lines x 4 words).
module tb_icache_dm_refill;

    logic        clk;
    logic        reset_n;
    logic        invalidate_all;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_vec  = 0;
    int n_miss = 0;

    icache_dm_refill_if #(.ADDR_W(32), .DATA_W(32)) cpu_bus ();
    icache_dm_refill_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    icache_dm_refill #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .NUM_LINES      (64),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu            (cpu_bus),
        .mem            (mem_bus),
        .invalidate_all (invalidate_all),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One fetch expected to miss: grant after gwait cycles (stray beats driven while
    // waiting), four beats base+0..base+3, optional invalidate or reset on a given beat.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] base, input int gwait,
                           input int inv_beat, input int rst_beat, input logic [31:0] exp_miss);
        logic [31:0] line_addr;
        logic [31:0] word_sel;
        line_addr = addr & 32'hFFFF_FFF0;
        word_sel  = (addr >> 2) & 32'h0000_0003;
        cpu_bus.req_valid = 1'b1;
        cpu_bus.req_addr  = addr;
        #1;
        check_val("miss_accept_ready", 64'(cpu_bus.req_ready), 64'h1);
        tick();
        cpu_bus.req_valid = 1'b0;
        cpu_bus.req_addr  = 32'h0;
        check_val("mreq_valid", 64'(mem_bus.req_valid), 64'h1);
        check_val("mreq_addr", 64'(mem_bus.req_addr), 64'(line_addr));
        check_val("miss_count", 64'(miss_count), 64'(exp_miss));
        check_val("mreq_cpu_ready", 64'(cpu_bus.req_ready), 64'h0);
        for (int i = 0; i < gwait; i++) begin
            mem_bus.resp_valid = 1'b1;
            mem_bus.resp_data  = 32'h0000_0BAD;
            tick();
            mem_bus.resp_valid = 1'b0;
            check_val("wait_mreq_valid", 64'(mem_bus.req_valid), 64'h1);
            check_val("wait_mreq_addr", 64'(mem_bus.req_addr), 64'(line_addr));
            check_val("wait_cpu_ready", 64'(cpu_bus.req_ready), 64'h0);
        end
        mem_bus.req_ready = 1'b1;
        tick();
        mem_bus.req_ready = 1'b0;
        check_val("grant_mreq_drop", 64'(mem_bus.req_valid), 64'h0);
        for (int b = 0; b < 4; b++) begin
            mem_bus.resp_valid = 1'b1;
            mem_bus.resp_data  = base + 32'(b);
            invalidate_all     = (b == inv_beat);
            check_val("refill_no_resp", 64'(cpu_bus.resp_valid), 64'h0);
            if (b == rst_beat) begin
                reset_n = 1'b0;
                #1;
                check_val("rst_mreq_valid", 64'(mem_bus.req_valid), 64'h0);
                check_val("rst_resp_valid", 64'(cpu_bus.resp_valid), 64'h0);
                check_val("rst_resp_hit", 64'(cpu_bus.resp_hit), 64'h0);
                check_val("rst_resp_data", 64'(cpu_bus.resp_data), 64'h0);
                check_val("rst_hit_count", 64'(hit_count), 64'h0);
                check_val("rst_miss_count", 64'(miss_count), 64'h0);
                check_val("rst_cpu_ready", 64'(cpu_bus.req_ready), 64'h1);
                mem_bus.resp_valid = 1'b0;
                invalidate_all     = 1'b0;
                return;
            end
            tick();
        end
        mem_bus.resp_valid = 1'b0;
        invalidate_all     = 1'b0;
        check_val("miss_resp_valid", 64'(cpu_bus.resp_valid), 64'h1);
        check_val("miss_resp_hit", 64'(cpu_bus.resp_hit), 64'h0);
        check_val("miss_resp_data", 64'(cpu_bus.resp_data), 64'(base + word_sel));
        tick();
        check_val("miss_resp_pulse", 64'(cpu_bus.resp_valid), 64'h0);
    endtask

    // One fetch expected to hit, response checked the following cycle.
    task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [31:0] exp_hits);
        cpu_bus.req_valid = 1'b1;
        cpu_bus.req_addr  = addr;
        #1;
        check_val("hit_accept_ready", 64'(cpu_bus.req_ready), 64'h1);
        tick();
        cpu_bus.req_valid = 1'b0;
        check_val("hit_resp_valid", 64'(cpu_bus.resp_valid), 64'h1);
        check_val("hit_resp_hit", 64'(cpu_bus.resp_hit), 64'h1);
        check_val("hit_resp_data", 64'(cpu_bus.resp_data), 64'(exp_data));
        check_val("hit_count", 64'(hit_count), 64'(exp_hits));
        tick();
        check_val("hit_resp_pulse", 64'(cpu_bus.resp_valid), 64'h0);
    endtask

    // Directed sequence.
    initial begin
        reset_n            = 1'b0;
        invalidate_all     = 1'b0;
        cpu_bus.req_valid  = 1'b0;
        cpu_bus.req_addr   = 32'h0;
        mem_bus.req_ready  = 1'b0;
        mem_bus.resp_valid = 1'b0;
        mem_bus.resp_data  = 32'h0;
        mem_bus.resp_hit   = 1'b0;
        tick();
        tick();
        check_val("reset_cpu_ready", 64'(cpu_bus.req_ready), 64'h1);
        check_val("reset_resp_valid", 64'(cpu_bus.resp_valid), 64'h0);
        check_val("reset_resp_hit", 64'(cpu_bus.resp_hit), 64'h0);
        check_val("reset_resp_data", 64'(cpu_bus.resp_data), 64'h0);
        check_val("reset_mreq_valid", 64'(mem_bus.req_valid), 64'h0);
        check_val("reset_hit_count", 64'(hit_count), 64'h0);
        check_val("reset_miss_count", 64'(miss_count), 64'h0);
        reset_n = 1'b1;
        tick();

        // Cold miss, response word 1 of the line.
        do_miss(32'h0000_1004, 32'h0000_00A0, 0, -1, -1, 32'd1);

        // Back-to-back hits on the same line.
        cpu_bus.req_valid = 1'b1;
        cpu_bus.req_addr  = 32'h0000_1008;
        tick();
        check_val("b2b_resp1_valid", 64'(cpu_bus.resp_valid), 64'h1);
        check_val("b2b_resp1_hit", 64'(cpu_bus.resp_hit), 64'h1);
        check_val("b2b_resp1_data", 64'(cpu_bus.resp_data), 64'h0000_00A2);
        cpu_bus.req_addr = 32'h0000_100C;
        tick();
        cpu_bus.req_valid = 1'b0;
        check_val("b2b_resp2_valid", 64'(cpu_bus.resp_valid), 64'h1);
        check_val("b2b_resp2_hit", 64'(cpu_bus.resp_hit), 64'h1);
        check_val("b2b_resp2_data", 64'(cpu_bus.resp_data), 64'h0000_00A3);
        check_val("b2b_hit_count", 64'(hit_count), 64'h2);
        tick();
        check_val("b2b_resp_end", 64'(cpu_bus.resp_valid), 64'h0);

        // Conflict on index 0, then the evicted line misses again with a slow grant.
        do_miss(32'h0000_1404, 32'h0000_00B0, 0, -1, -1, 32'd2);
        do_miss(32'h0000_1004, 32'h0000_00C0, 5, -1, -1, 32'd3);
        do_hit(32'h0000_100C, 32'h0000_00C3, 32'd3);

        // Invalidate during beat 2: response still delivered, clear on IDLE entry.
        do_miss(32'h0000_2008, 32'h0000_00D0, 0, 2, -1, 32'd4);
        check_val("inv_idle_entry_ready", 64'(cpu_bus.req_ready), 64'h0);
        tick();
        check_val("inv_after_ready", 64'(cpu_bus.req_ready), 64'h1);
        do_miss(32'h0000_2008, 32'h0000_00E0, 0, -1, -1, 32'd5);
        check_val("inv_hit_count", 64'(hit_count), 64'h3);

        // Invalidate while IDLE: request blocked, line gone afterwards.
        invalidate_all    = 1'b1;
        cpu_bus.req_valid = 1'b1;
        cpu_bus.req_addr  = 32'h0000_2008;
        #1;
        check_val("idle_inv_ready", 64'(cpu_bus.req_ready), 64'h0);
        tick();
        invalidate_all    = 1'b0;
        cpu_bus.req_valid = 1'b0;
        check_val("idle_inv_no_resp", 64'(cpu_bus.resp_valid), 64'h0);
        check_val("idle_inv_hit_count", 64'(hit_count), 64'h3);
        do_miss(32'h0000_2008, 32'h0000_0060, 0, -1, -1, 32'd6);

        // Reset dropped during beat 1: no response, counters cleared, line not installed.
        do_miss(32'h0000_3000, 32'h0000_00F0, 0, -1, 1, 32'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_hold_resp", 64'(cpu_bus.resp_valid), 64'h0);
        end
        reset_n = 1'b1;
        tick();
        check_val("rst_rel_resp", 64'(cpu_bus.resp_valid), 64'h0);
        check_val("rst_rel_mreq", 64'(mem_bus.req_valid), 64'h0);
        do_miss(32'h0000_3000, 32'h0000_00F0, 0, -1, -1, 32'd1);
        do_hit(32'h0000_3004, 32'h0000_00F1, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
